fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_skid_buf.sv | 29 ++
 rtl/fetch_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  // FETCH: request outstanding; DROP: request outstanding, response discarded;
  // BUF: no request, one fetched word parked in the skid buffer.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    BUF   = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched word and its pc while IF/ID is stalled.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  // Capture on load; clear drops the entry (drain or flush).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= 32'h0;
      pc    <= 32'h0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= in_instr;
      pc    <= in_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, redirect flush and stall skid buffer.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;

  logic         ifid_load, ifid_flush, ifid_bubble;
  logic [31:0]  ld_instr, ld_pc;
  logic         buf_load, buf_clear, buf_valid;
  logic [31:0]  buf_instr, buf_pc;

  fetch_skid_buf u_skid_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .clear    (buf_clear),
    .in_instr (imem_rdata),
    .in_pc    (pc_q),
    .valid    (buf_valid),
    .instr    (buf_instr),
    .pc       (buf_pc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic; redirect always wins over stall.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (redirect)                 state_d = imem_ready ? FETCH : DROP;
        else if (imem_ready && stall) state_d = BUF;
      end
      DROP:    if (imem_ready) state_d = FETCH;
      BUF:     if (redirect || !stall) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Outputs decoded from state; no request while reset is held.
  always_comb begin
    imem_req = !rst && (state_q != BUF);
  end

  // Datapath control: next pc, stored redirect target, IF/ID and buffer actions.
  always_comb begin
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    ifid_load   = 1'b0;
    ifid_flush  = 1'b0;
    ifid_bubble = 1'b0;
    ld_instr    = imem_rdata;
    ld_pc       = pc_q;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          // Accepted response is thrown away; a pending one must be drained first.
          if (imem_ready) pc_d = redirect_pc;
          else            tgt_d = redirect_pc;
        end else if (imem_ready) begin
          if (stall) begin
            buf_load = 1'b1;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_q + PC_INC;
          end
        end else if (!stall) begin
          ifid_bubble = 1'b1;
        end
      end
      DROP: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          tgt_d      = redirect_pc;
        end else if (!stall) begin
          ifid_bubble = 1'b1;
        end
        if (imem_ready) pc_d = redirect ? redirect_pc : tgt_q;
      end
      BUF: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          buf_clear  = 1'b1;
          pc_d       = redirect_pc;
        end else if (!stall) begin
          ifid_load = buf_valid;
          ld_instr  = buf_instr;
          ld_pc     = buf_pc;
          buf_clear = 1'b1;
          pc_d      = buf_pc + PC_INC;
        end
      end
      default: ;
    endcase
  end

  // Fetch pc and stored redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      tgt_q <= RESET_PC;
    end else begin
      pc_q  <= pc_d;
      tgt_q <= tgt_d;
    end
  end

  assign imem_addr = pc_q;

  // IF/ID register: flush beats load; a bubble only drops the valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= 32'h0;
      ifid_pc4   <= 32'h0;
      ifid_instr <= NOP_INSTR;
    end else if (ifid_flush) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end else if (ifid_load) begin
      ifid_valid <= 1'b1;
      ifid_pc    <= ld_pc;
      ifid_pc4   <= ld_pc + PC_INC;
      ifid_instr <= ld_instr;
    end else if (ifid_bubble) begin
      ifid_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  // Count valid IF/ID loads and stalled cycles; both wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (ifid_load && !ifid_flush) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall)                    stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule
